vcve2_vrf_mem_responder: RTL
============================

VCVE2_VRF_MEM_RESPONDER -- requirements
Module: vcve2_vrf_mem_responder

Interface
REQ-001 SHALL have parameter VLEN, default 128, meaning bits per vector register.
REQ-002 SHALL have parameter NumVregs, default 32, meaning number of vector registers stored.
REQ-003 SHALL have parameter GntDelay, default 0, range 0..7, meaning wait cycles from request to grant.
REQ-004 SHALL have parameter RvalidLatency, default 1, range 1..4, meaning cycles from grant to rvalid.
REQ-005 SHALL derive NumWords = NumVregs*VLEN/32, the 32-bit word count (128 at defaults).
REQ-006 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port data_req_i  input  1  request valid from the VRF interface.
REQ-009 SHALL have port data_we_i  input  1  1 = write, 0 = read.
REQ-010 SHALL have port data_be_i  input  4  byte enables for writes.
REQ-011 SHALL have port data_addr_i  input  32  byte address.
REQ-012 SHALL have port data_wdata_i  input  32  write data.
REQ-013 SHALL have port stall_i  input  1  blocks grant while high (bank busy).
REQ-014 SHALL have port data_gnt_o  output  1  request accepted this cycle.
REQ-015 SHALL have port data_rvalid_o  output  1  response valid; one per granted request.
REQ-016 SHALL have port data_err_o  output  1  error flag, valid with rvalid.
REQ-017 SHALL have port data_rdata_o  output  32  read data, valid with rvalid.

Function
REQ-018 SHALL store NumWords x 32-bit words; index = data_addr_i[$clog2(NumWords)+1:2].
REQ-019 SHALL run grant FSM states GNT_IDLE and GNT_WAIT plus a 3-bit wait counter.
REQ-020 GNT_IDLE, GntDelay=0: data_gnt_o = data_req_i & !stall_i combinationally; stays in GNT_IDLE.
REQ-021 GNT_IDLE, GntDelay>0, data_req_i high: SHALL load counter with GntDelay-1, go to GNT_WAIT, no grant.
REQ-022 GNT_WAIT: SHALL decrement counter to zero; at zero, data_gnt_o = data_req_i & !stall_i; on grant, return to GNT_IDLE.
REQ-023 GNT_WAIT with data_req_i low (protocol violation): SHALL return to GNT_IDLE, no grant, no memory access.
REQ-024 stall_i high SHALL suppress grant in any state without changing state or counter (counter held at zero).
REQ-025 Error: address misaligned (addr[1:0]!=0) or addr >= 4*NumWords; SHALL then perform no write and return rdata 0.
REQ-026 Write on grant: SHALL update only bytes with data_be_i set at that clock edge; response rdata = 0, err per REQ-025.
REQ-027 Read on grant: SHALL capture the word at that edge; a write granted the previous cycle to the same address SHALL be visible.
REQ-028 SHALL assert data_rvalid_o exactly RvalidLatency cycles after each grant, in grant order, for one cycle per grant.
REQ-029 Back-to-back grants SHALL produce back-to-back rvalids; there is no response backpressure.
REQ-030 data_rdata_o and data_err_o SHALL be 0 whenever data_rvalid_o is low.

Reset
REQ-031 With rst_i high at a rising edge: FSM -> GNT_IDLE, counter -> 0, response pipeline flushed (in-flight responses dropped).
REQ-032 During reset and the cycle after: data_gnt_o=0, data_rvalid_o=0, data_err_o=0, data_rdata_o=0.
REQ-033 Storage contents SHALL NOT be cleared by reset; they are undefined until written.

Structure
REQ-034 vcve2_pkg SHALL hold typedef gnt_state_e {GNT_IDLE, GNT_WAIT} and constant VRF_WORD_BYTES = 4.
REQ-035 The response delay line SHALL be sub-module vcve2_rsp_pipe, parameterized by RvalidLatency, carrying {valid, err, rdata}.

Verification
REQ-036 GntDelay=0, RvalidLatency=1: write 0xDEADBEEF to 0x10 with be=0xF, then read 0x10 -> gnt in the request cycle; read rvalid next cycle with rdata 0xDEADBEEF, err 0.
REQ-037 Byte merge: word 0x11223344 at 0x20, then write 0xAABBCCDD with be=0x5 -> read returns 0x11BB33DD.
REQ-038 GntDelay=3: req held from cycle 0 -> gnt in cycle 3 only; with stall_i high in cycle 3, gnt moves to cycle 4.
REQ-039 Error cases: read 0x202 (misaligned) and 0x200 (out of range at defaults) -> rvalid with err 1, rdata 0; a write to 0x200 changes no stored word.
REQ-040 RvalidLatency=3: four back-to-back reads of 0x0,0x4,0x8,0xC -> rvalid in four consecutive cycles starting 3 cycles after the first grant, data in order.
REQ-041 rst_i asserted with two responses in flight -> no rvalid after reset; memory retains the written values.

Source files
------------

// File: rtl/vcve2_pkg.sv
// Shared types and constants for the VRF memory responder.
package vcve2_pkg;

  // Bytes per stored word; addresses are byte addresses, words are 32 bits.
  localparam int unsigned VRF_WORD_BYTES = 4;

  // Grant FSM: idle, or counting down wait cycles before a grant.
  typedef enum logic [0:0] {
    GNT_IDLE = 1'b0,
    GNT_WAIT = 1'b1
  } gnt_state_e;

  // One response slot travelling down the response delay line.
  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

endpackage

// File: rtl/vcve2_rsp_pipe.sv
// Fixed-latency response delay line carrying {valid, err, rdata}.
// A synchronous reset empties every stage, dropping in-flight responses.
module vcve2_rsp_pipe
  import vcve2_pkg::*;
#(
  parameter int unsigned RvalidLatency = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  rsp_t rsp_i,
  output rsp_t rsp_o
);

  rsp_t stage_q [RvalidLatency];

  // Shift responses one stage per cycle; reset flushes all stages.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(RvalidLatency); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= rsp_i;
      for (int i = 1; i < int'(RvalidLatency); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign rsp_o = stage_q[RvalidLatency-1];

endmodule

// File: rtl/vcve2_vrf_mem_responder.sv
// Word-addressed memory model behind the VRF data interface: a grant FSM
// with configurable grant delay and stall, byte-enabled writes, and a
// fixed-latency in-order response path.
//
// Handshake: a request is accepted in the cycle where data_req_i and
// data_gnt_o are both high; exactly one data_rvalid_o pulse follows it
// RvalidLatency cycles later. Responses cannot be back-pressured.
module vcve2_vrf_mem_responder
  import vcve2_pkg::*;
#(
  parameter int unsigned VLEN          = 128,
  parameter int unsigned NumVregs      = 32,
  parameter int unsigned GntDelay      = 0,
  parameter int unsigned RvalidLatency = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic        stall_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic        data_err_o,
  output logic [31:0] data_rdata_o,
  output gnt_state_e  dbg_gnt_state_o
);

  localparam int unsigned NumWords  = NumVregs * VLEN / 32;
  localparam int unsigned IdxW      = $clog2(NumWords);
  localparam logic [32:0] AddrLimit = 33'(VRF_WORD_BYTES * NumWords);
  // Counter start value; only meaningful when GntDelay > 0.
  localparam logic [2:0]  CntLoad   = (GntDelay > 0) ? 3'(GntDelay - 1) : 3'd0;

  gnt_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        rst_q;
  logic        blocked;
  logic        gnt;
  logic        addr_err;
  logic [IdxW-1:0] idx;
  logic [31:0] mem_q [NumWords];
  rsp_t        rsp_in, rsp_out;

  // Grants are held off by a busy bank, during reset, and the cycle after.
  assign blocked = stall_i | rst_i | rst_q;

  // Grant FSM state, wait counter and the one-cycle post-reset marker.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= GNT_IDLE;
      cnt_q   <= 3'd0;
      rst_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= 1'b0;
    end
  end

  // Next-state and grant decode; a blocked cycle freezes state and counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    unique case (state_q)
      GNT_IDLE: begin
        if (GntDelay == 0) begin
          gnt = data_req_i & ~blocked;
        end else if (data_req_i & ~blocked) begin
          cnt_d   = CntLoad;
          state_d = GNT_WAIT;
        end
      end
      GNT_WAIT: begin
        if (!data_req_i) begin
          // Requester withdrew: abandon the wait without a grant.
          state_d = GNT_IDLE;
          cnt_d   = 3'd0;
        end else if (blocked) begin
          state_d = state_q;
        end else if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          gnt     = 1'b1;
          state_d = GNT_IDLE;
        end
      end
      default: begin
        state_d = GNT_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  assign data_gnt_o      = gnt;
  assign dbg_gnt_state_o = state_q;

  // Misaligned or past-the-end addresses are errors and never touch storage.
  assign addr_err = (data_addr_i[1:0] != 2'b00) || ({1'b0, data_addr_i} >= AddrLimit);
  assign idx      = data_addr_i[IdxW+1:2];

  // Byte-enabled write on grant; storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (gnt && data_we_i && !addr_err) begin
      for (int b = 0; b < VRF_WORD_BYTES; b++) begin
        if (data_be_i[b]) begin
          mem_q[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Response captured at the grant edge; err/rdata are zero when not valid.
  always_comb begin
    rsp_in       = '0;
    rsp_in.valid = gnt;
    rsp_in.err   = gnt & addr_err;
    if (gnt && !data_we_i && !addr_err) begin
      rsp_in.rdata = mem_q[idx];
    end
  end

  vcve2_rsp_pipe #(
    .RvalidLatency(RvalidLatency)
  ) u_rsp_pipe (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .rsp_i (rsp_in),
    .rsp_o (rsp_out)
  );

  assign data_rvalid_o = rsp_out.valid & ~rst_i;
  assign data_err_o    = rsp_out.err   & rsp_out.valid & ~rst_i;
  assign data_rdata_o  = (rsp_out.valid & ~rst_i) ? rsp_out.rdata : 32'd0;

endmodule
